// File: rtl/sdrstick_rx_packer.sv
// Multi-channel receiver sample packer: captures one I/Q frame per channel, round-robin
// serialises frames (optional header, sign-extended or packed-16 data) into a 32-bit FIFO.
module sdrstick_rx_packer #(
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned SAMPLE_W = 24,
   parameter int unsigned OVF_W    = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NUM_CH-1:0]          in_strobe,
   input  logic [NUM_CH*SAMPLE_W-1:0] in_i,
   input  logic [NUM_CH*SAMPLE_W-1:0] in_q,
   output logic [31:0]                fifo_writedata,
   output logic                       fifo_write,
   input  logic                       fifo_full,
   input  logic [2:0]                 ctl_address,
   input  logic                       ctl_read,
   output logic [31:0]                ctl_readdata,
   input  logic                       ctl_write,
   input  logic [31:0]                ctl_writedata
);

   localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {StIdle, StHdr, StData0, StData1} state_e;

   state_e                state_q, state_d;
   logic [2:0]            ctrl_q, ctrl_d;
   logic [NUM_CH-1:0]     mask_q, mask_d, sticky_q, sticky_d;
   logic [OVF_W-1:0]      ovf_q, ovf_d;
   logic [OVF_W:0]        ovf_sum;
   logic [31:0]           frames_q, frames_d;
   logic [NUM_CH-1:0]     strobe_q, pending_q, pending_d;
   logic [NUM_CH-1:0]     capture, ovf_vec, eff_pend, granted_vec;
   logic [CW-1:0]         rr_q, rr_d, grant, out_ch_q;
   logic                  grant_valid, load, frame_done, enable;
   logic [SAMPLE_W-1:0]   hold_i_q [NUM_CH];
   logic [SAMPLE_W-1:0]   hold_q_q [NUM_CH];
   logic [SAMPLE_W-1:0]   out_i_q, out_q_q;
   logic                  out_fmt_q;
   logic [15:0]           seq_q [NUM_CH];
   logic [31:0]           wdata_q, wdata_d, rdata_q, rdata_d;
   logic                  unused_wdata;

   function automatic logic [31:0] sext(input logic [SAMPLE_W-1:0] v);
      logic signed [SAMPLE_W-1:0] s;
      s = v;
      return 32'(s);
   endfunction

   function automatic logic [31:0] pack16(input logic [SAMPLE_W-1:0] vi,
                                          input logic [SAMPLE_W-1:0] vq);
      return {vi[SAMPLE_W-1 -: 16], vq[SAMPLE_W-1 -: 16]};
   endfunction

   assign enable         = ctrl_q[0];
   assign eff_pend       = pending_q & mask_q & {NUM_CH{enable}};
   assign unused_wdata   = ^ctl_writedata;
   assign fifo_writedata = wdata_q;
   assign ctl_readdata   = rdata_q;
   // Strobe is gated by fifo_full so a word is never offered to a full FIFO
   assign fifo_write     = (state_q != StIdle) && !fifo_full;

   // Round-robin search for the first enabled pending channel at or after rr_q
   always_comb begin
      logic [CW:0] idx;
      grant_valid = 1'b0;
      grant       = '0;
      idx         = '0;
      for (int off = 0; off < int'(NUM_CH); off++) begin
         idx = {1'b0, rr_q} + (CW+1)'(off);
         if (idx >= (CW+1)'(NUM_CH)) idx = idx - (CW+1)'(NUM_CH);
         if (!grant_valid && eff_pend[idx[CW-1:0]]) begin
            grant_valid = 1'b1;
            grant       = idx[CW-1:0];
         end
      end
      if (state_q != StIdle) grant_valid = 1'b0;
      granted_vec = grant_valid ? (NUM_CH'(1) << grant) : '0;
      rr_d        = rr_q;
      if (grant_valid) rr_d = (grant == CW'(NUM_CH - 1)) ? '0 : grant + CW'(1);
   end

   // Edge capture, pending bookkeeping and overflow detection per channel
   always_comb begin
      pending_d = pending_q;
      capture   = '0;
      ovf_vec   = '0;
      ovf_sum   = {1'b0, ovf_q};
      for (int k = 0; k < int'(NUM_CH); k++) begin
         capture[k] = enable && mask_q[k] && in_strobe[k] && !strobe_q[k];
         if (!enable || !mask_q[k]) begin
            pending_d[k] = 1'b0;
         end else if (capture[k]) begin
            pending_d[k] = 1'b1;
            ovf_vec[k]   = pending_q[k] && !granted_vec[k];
         end else if (granted_vec[k]) begin
            pending_d[k] = 1'b0;
         end
         ovf_sum = ovf_sum + (OVF_W+1)'(ovf_vec[k]);
      end
   end

   // Word sequencer: first word is formed at grant, later words as each one is accepted
   always_comb begin
      state_d    = state_q;
      wdata_d    = wdata_q;
      load       = 1'b0;
      frame_done = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (grant_valid) begin
               load = 1'b1;
               if (ctrl_q[2]) begin
                  state_d = StHdr;
                  wdata_d = {8'hA5, 4'h0, 4'(grant), seq_q[grant]};
               end else begin
                  state_d = StData0;
                  wdata_d = ctrl_q[1] ? pack16(hold_i_q[grant], hold_q_q[grant])
                                      : sext(hold_i_q[grant]);
               end
            end
         end
         StHdr: begin
            if (!fifo_full) begin
               state_d = StData0;
               wdata_d = out_fmt_q ? pack16(out_i_q, out_q_q) : sext(out_i_q);
            end
         end
         StData0: begin
            if (!fifo_full) begin
               if (out_fmt_q) begin
                  state_d    = StIdle;
                  frame_done = 1'b1;
               end else begin
                  state_d = StData1;
                  wdata_d = sext(out_q_q);
               end
            end
         end
         StData1: begin
            if (!fifo_full) begin
               state_d    = StIdle;
               frame_done = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Control register updates and read-back mux
   always_comb begin
      ctrl_d   = ctrl_q;
      mask_d   = mask_q;
      sticky_d = sticky_q;
      ovf_d    = ovf_sum[OVF_W] ? '1 : ovf_sum[OVF_W-1:0];
      frames_d = frames_q + 32'(frame_done);
      if (ctl_write) begin
         unique case (ctl_address)
            3'd0:    ctrl_d   = ctl_writedata[2:0];
            3'd1:    mask_d   = ctl_writedata[NUM_CH-1:0];
            3'd2:    sticky_d = sticky_q & ~ctl_writedata[NUM_CH-1:0];
            3'd3:    ovf_d    = '0;
            3'd4:    frames_d = '0;
            default: ;
         endcase
      end
      // A new overflow in the clearing cycle stays visible
      sticky_d = sticky_d | ovf_vec;

      rdata_d = '0;
      unique case (ctl_address)
         3'd0: rdata_d[2:0] = ctrl_q;
         3'd1: rdata_d[NUM_CH-1:0] = mask_q;
         3'd2: begin
            rdata_d[NUM_CH-1:0] = sticky_q;
            rdata_d[31]         = (state_q != StIdle);
         end
         3'd3:    rdata_d[OVF_W-1:0] = ovf_q;
         3'd4:    rdata_d = frames_q;
         default: ;
      endcase
   end

   // State, control registers and sample datapath
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         ctrl_q    <= '0;
         mask_q    <= '0;
         sticky_q  <= '0;
         ovf_q     <= '0;
         frames_q  <= '0;
         strobe_q  <= '0;
         pending_q <= '0;
         rr_q      <= '0;
         out_ch_q  <= '0;
         out_i_q   <= '0;
         out_q_q   <= '0;
         out_fmt_q <= 1'b0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         for (int k = 0; k < int'(NUM_CH); k++) begin
            hold_i_q[k] <= '0;
            hold_q_q[k] <= '0;
            seq_q[k]    <= '0;
         end
      end else begin
         state_q   <= state_d;
         ctrl_q    <= ctrl_d;
         mask_q    <= mask_d;
         sticky_q  <= sticky_d;
         ovf_q     <= ovf_d;
         frames_q  <= frames_d;
         strobe_q  <= in_strobe;
         pending_q <= pending_d;
         rr_q      <= rr_d;
         wdata_q   <= wdata_d;
         if (ctl_read && !ctl_write) rdata_q <= rdata_d;
         for (int k = 0; k < int'(NUM_CH); k++) begin
            if (capture[k]) begin
               hold_i_q[k] <= in_i[k*SAMPLE_W +: SAMPLE_W];
               hold_q_q[k] <= in_q[k*SAMPLE_W +: SAMPLE_W];
            end
         end
         if (load) begin
            out_i_q   <= hold_i_q[grant];
            out_q_q   <= hold_q_q[grant];
            out_ch_q  <= grant;
            out_fmt_q <= ctrl_q[1];
         end
         if (frame_done) seq_q[out_ch_q] <= seq_q[out_ch_q] + 16'd1;
      end
   end

endmodule
